// File: rtl/stereo_disparity_engine.sv
// -----------------------------------------------------------------------------
// stereo_disparity_engine
//
// Row-based stereo block matcher. One left and one right row are captured.
// For each WIN-pixel block of the right row, the engine then tries MAX_DISP
// candidate shifts into the left row, one candidate per cycle, scoring each
// with SAD or SSD. The row is then replayed as one disparity value and one
// false-colour RGB value per pixel.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid           left/right pixel pair valid
//   i_data_l/_r       left / right grey pixel (PIX_W bits)
//   o_ready           pair accepted this cycle (high only while fetching)
//   o_valid, i_ready  output pixel handshake
//   o_disp            disparity of the current output pixel
//   o_data_R/G/B      false-colour value (10 bits each)
//   o_done            1-cycle pulse after the last pixel of a row is taken
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. o_valid, once raised, stays high and o_disp/o_data_* stay
// stable until the transfer. o_ready is a function of state only.
//
// Phases: FETCH (capture IMG_W pairs) -> CALC (NBLK*MAX_DISP cycles) ->
// OUT (IMG_W pixels) -> FETCH. r_state is the FSM state register.
// -----------------------------------------------------------------------------
module stereo_disparity_engine #(
    parameter int PIX_W     = 9,
    parameter int IMG_W     = 800,
    parameter int WIN       = 4,
    parameter int MAX_DISP  = 10,
    parameter int COST_MODE = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid,
    input  logic [PIX_W-1:0]            i_data_l,
    input  logic [PIX_W-1:0]            i_data_r,
    output logic                        o_ready,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [$clog2(MAX_DISP)-1:0] o_disp,
    output logic [9:0]                  o_data_R,
    output logic [9:0]                  o_data_G,
    output logic [9:0]                  o_data_B,
    output logic                        o_done
);

    localparam int NBLK = IMG_W / WIN;
    localparam int DW   = $clog2(MAX_DISP);
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    // Per-tap term width: |diff| fits in PIX_W bits, diff^2 in 2*PIX_W bits.
    localparam int TW   = (COST_MODE != 0) ? 2 * PIX_W : PIX_W;
    // One spare bit keeps every real cost strictly below the all-ones seed.
    localparam int CW   = TW + $clog2(WIN) + 1;
    // Left-row index can run past the row end for invalid candidates.
    localparam int LW   = $clog2(IMG_W + WIN + MAX_DISP) + 1;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    logic [1:0]       r_state;
    logic [XW-1:0]    r_x;
    logic [BW-1:0]    r_blk;
    logic [DW-1:0]    r_d;
    logic [CW-1:0]    r_best_cost;
    logic [DW-1:0]    r_best_d;
    logic             r_valid;
    logic             r_done;
    logic [DW-1:0]    r_disp;
    logic [9:0]       r_red;
    logic [9:0]       r_grn;
    logic [9:0]       r_blu;

    logic [PIX_W-1:0] r_row_l    [IMG_W];
    logic [PIX_W-1:0] r_row_r    [IMG_W];
    logic [DW-1:0]    r_disp_buf [NBLK];

    logic             w_accept_in;
    logic             w_last_pix;
    logic             w_blk_end;
    logic [XW-1:0]    w_next_x;
    logic [BW-1:0]    w_next_blk;
    logic [LW-1:0]    w_base;
    logic [TW-1:0]    w_term [WIN];
    logic [CW-1:0]    w_cost;
    logic             w_cand_ok;
    logic [CW-1:0]    w_prev_best;
    logic             w_take;
    logic [CW-1:0]    w_new_cost;
    logic [DW-1:0]    w_new_d;
    logic [DW-1:0]    w_load_disp;
    logic [29:0]      w_load_rgb;

    // Ten-step false-colour ramp from red through green to violet.
    function automatic logic [29:0] f_colour(input logic [DW-1:0] disp);
        int idx;
        idx = (int'(disp) * 10) / MAX_DISP;
        case (idx)
            0:       f_colour = {10'd255, 10'd0,   10'd0};
            1:       f_colour = {10'd255, 10'd64,  10'd0};
            2:       f_colour = {10'd255, 10'd136, 10'd0};
            3:       f_colour = {10'd255, 10'd221, 10'd0};
            4:       f_colour = {10'd153, 10'd255, 10'd0};
            5:       f_colour = {10'd26,  10'd255, 10'd0};
            6:       f_colour = {10'd0,   10'd255, 10'd162};
            7:       f_colour = {10'd0,   10'd212, 10'd255};
            8:       f_colour = {10'd0,   10'd98,  10'd255};
            default: f_colour = {10'd47,  10'd0,   10'd255};
        endcase
    endfunction

    assign w_accept_in = (r_state == ST_FETCH) && i_valid;
    assign w_last_pix  = (r_x == XW'(IMG_W - 1));
    assign w_blk_end   = (r_d == DW'(MAX_DISP - 1));
    assign w_next_x    = r_x + XW'(1);
    assign w_next_blk  = BW'(w_next_x / XW'(WIN));

    // ---- candidate cost: all WIN taps of block r_blk at shift r_d ----------
    assign w_base = LW'(r_blk) * LW'(WIN);

    for (genvar k = 0; k < WIN; k++) begin : g_tap
        logic [LW-1:0]          w_ridx;
        logic [LW-1:0]          w_lidx;
        logic [PIX_W-1:0]       w_pr;
        logic [PIX_W-1:0]       w_pl;
        logic signed [PIX_W:0]  w_diff;
        logic signed [PIX_W:0]  w_neg;
        logic [PIX_W-1:0]       w_mag;

        assign w_ridx = w_base + LW'(k);
        assign w_lidx = w_ridx + LW'(r_d);
        assign w_pr   = r_row_r[w_ridx[XW-1:0]];
        // Past the row end the tap is a don't-care (candidate is skipped).
        assign w_pl   = (w_lidx < LW'(IMG_W)) ? r_row_l[w_lidx[XW-1:0]] : '0;
        assign w_diff = $signed({1'b0, w_pr}) - $signed({1'b0, w_pl});
        assign w_neg  = -w_diff;
        assign w_mag  = w_diff[PIX_W] ? w_neg[PIX_W-1:0] : w_diff[PIX_W-1:0];
        assign w_term[k] = (COST_MODE != 0) ? TW'(w_mag) * TW'(w_mag) : TW'(w_mag);
    end

    always_comb begin
        w_cost = '0;
        for (int k = 0; k < WIN; k++) begin
            w_cost = w_cost + CW'(w_term[k]);
        end
    end

    assign w_cand_ok   = (w_base + LW'(WIN - 1) + LW'(r_d)) < LW'(IMG_W);
    // Each block starts from an all-ones best cost, so d=0 always wins first.
    assign w_prev_best = (r_d == '0) ? '1 : r_best_cost;
    // Strictly lower only: ties keep the earlier (smaller) disparity.
    assign w_take      = w_cand_ok && (w_cost < w_prev_best);
    assign w_new_cost  = w_take ? w_cost : w_prev_best;
    assign w_new_d     = w_take ? r_d : r_best_d;

    // Pixel 0 is loaded on the last CALC cycle; with a single block its
    // disparity is still being decided, so bypass the buffer.
    assign w_load_disp = (r_state == ST_CALC)
                       ? ((r_blk == '0) ? w_new_d : r_disp_buf[0])
                       : r_disp_buf[w_next_blk];
    assign w_load_rgb  = f_colour(w_load_disp);

    // ---- storage (not reset: contents are rewritten before use) -----------
    always_ff @(posedge clk) begin
        if (w_accept_in) begin
            r_row_l[r_x] <= i_data_l;
            r_row_r[r_x] <= i_data_r;
        end
        if ((r_state == ST_CALC) && w_blk_end) begin
            r_disp_buf[r_blk] <= w_new_d;
        end
    end

    // ---- control and output registers -------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FETCH;
            r_x         <= '0;
            r_blk       <= '0;
            r_d         <= '0;
            r_best_cost <= '0;
            r_best_d    <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_disp      <= '0;
            r_red       <= '0;
            r_grn       <= '0;
            r_blu       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (i_valid) begin
                        if (w_last_pix) begin
                            r_x     <= '0;
                            r_blk   <= '0;
                            r_d     <= '0;
                            r_state <= ST_CALC;
                        end else begin
                            r_x <= w_next_x;
                        end
                    end
                end
                ST_CALC: begin
                    r_best_cost <= w_new_cost;
                    r_best_d    <= w_new_d;
                    if (w_blk_end) begin
                        r_d <= '0;
                        if (r_blk == BW'(NBLK - 1)) begin
                            r_blk   <= '0;
                            r_x     <= '0;
                            r_state <= ST_OUT;
                            r_valid <= 1'b1;
                            r_disp  <= w_load_disp;
                            {r_red, r_grn, r_blu} <= w_load_rgb;
                        end else begin
                            r_blk <= r_blk + BW'(1);
                        end
                    end else begin
                        r_d <= r_d + DW'(1);
                    end
                end
                ST_OUT: begin
                    if (r_valid && i_ready) begin
                        if (w_last_pix) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_x     <= '0;
                            r_state <= ST_FETCH;
                        end else begin
                            r_x    <= w_next_x;
                            r_disp <= w_load_disp;
                            {r_red, r_grn, r_blu} <= w_load_rgb;
                        end
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign o_ready  = (r_state == ST_FETCH);
    assign o_valid  = r_valid;
    assign o_done   = r_done;
    assign o_disp   = r_disp;
    assign o_data_R = r_red;
    assign o_data_G = r_grn;
    assign o_data_B = r_blu;

endmodule
